// File: rtl/sipo_pkg.sv
// Shared types and default constants for the serial-to-parallel word collector.
package sipo_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int         DEF_WIDTH     = 8;
  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial shift register with enable and selectable shift direction.
// sr_next_o is the value the register would take on the next qualified bit.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] sr_o,
  output logic [WIDTH-1:0] sr_next_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_next_o = {sr_q[WIDTH-2:0], bit_i};
    end else begin : g_lsb_first
      assign sr_next_o = {bit_i, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (en_i) sr_d = sr_next_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '0;
    else      sr_q <= sr_d;
  end

  assign sr_o = sr_q;

endmodule

// File: rtl/sipo_word_collector.sv
// Hunts for SYNC_WORD in a qualified serial stream, then assembles WIDTH-bit
// words into a one-entry valid/ready holding register with sticky overflow.
module sipo_word_collector
  import sipo_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_en,
  input  logic                     resync,
  input  logic                     word_ready,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  output logic                     locked,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              word_done;
  logic              shift_en;
  logic [WIDTH-1:0]  sr_cur;
  logic [WIDTH-1:0]  sr_next;

  // resync wins over bit_en: the bit presented alongside it is discarded.
  assign shift_en = bit_en & ~resync;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .en_i      (shift_en),
    .bit_i     (bit_in),
    .sr_o      (sr_cur),
    .sr_next_o (sr_next)
  );

  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    word_done = 1'b0;

    if (resync) begin
      state_d   = HUNT;
      fill_d    = '0;
      bit_cnt_d = '0;
    end else if (bit_en) begin
      case (state_q)
        HUNT: begin
          fill_d = fill_inc;
          // The fill guard stops an all-zero SYNC_WORD matching the reset state.
          if (fill_inc == FILL_MAX && sr_next == SYNC_WORD) begin
            state_d   = LOCKED;
            bit_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clr_ovf) ovf_d = 1'b0;

    if (word_done) begin
      if (!valid_q || word_ready) begin
        word_d  = sr_next;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= HUNT;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign locked     = (state_q == LOCKED);
  assign overflow   = ovf_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_sipo_word_collector.sv
// Directed bench for sipo_word_collector (WIDTH=8, SYNC_WORD=8'hA5, MSB first).
module tb_sipo_word_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_en;
  logic       resync;
  logic       word_ready;
  logic       clr_ovf;
  logic [7:0] word_out;
  logic       word_valid;
  logic       locked;
  logic       overflow;
  logic [2:0] bit_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_word_collector #(
    .WIDTH     (8),
    .SYNC_WORD (8'hA5),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .resync     (resync),
    .word_ready (word_ready),
    .clr_ovf    (clr_ovf),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .overflow   (overflow),
    .bit_cnt    (bit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".word_out"},   32'(word_out),   32'h0);
    check({tag, ".word_valid"}, 32'(word_valid), 32'h0);
    check({tag, ".locked"},     32'(locked),     32'h0);
    check({tag, ".overflow"},   32'(overflow),   32'h0);
    check({tag, ".bit_cnt"},    32'(bit_cnt),    32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    bit_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send(v[i]);
  endtask

  initial begin
    logic [7:0]  gap_word;
    logic [15:0] b2b;
    logic [7:0]  sync_pat;

    rst = 1'b0; bit_in = 1'b1; bit_en = 1'b0; resync = 1'b0;
    word_ready = 1'b0; clr_ovf = 1'b0;

    // 1. Reset held with bit_en toggling, then idle after release
    for (int i = 0; i < 3; i++) begin
      bit_en = ~bit_en;
      tick();
    end
    check_zero("rst_hold");
    rst = 1'b1;
    bit_en = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_zero("rst_idle");

    // 2. Lock behind garbage
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      check("garbage.locked", 32'(locked), 32'h0);
    end
    sync_pat = 8'hA5;
    for (int i = 7; i >= 1; i--) begin
      send(sync_pat[i]);
      check("sync_partial.locked", 32'(locked), 32'h0);
    end
    send(sync_pat[0]);
    check("sync.locked",     32'(locked),     32'h1);
    check("sync.word_valid", 32'(word_valid), 32'h0);
    check("sync.bit_cnt",    32'(bit_cnt),    32'h0);

    // 3. Word with two idle cycles between bits
    word_ready = 1'b1;
    gap_word = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      send(gap_word[i]);
      if (i == 5) check("gap.bit_cnt3", 32'(bit_cnt), 32'h3);
      if (i != 0) begin
        check("gap.valid_early", 32'(word_valid), 32'h0);
        tick();
        tick();
        check("gap.valid_idle", 32'(word_valid), 32'h0);
      end
    end
    check("gap.word_valid", 32'(word_valid), 32'h1);
    check("gap.word_out",   32'(word_out),   32'h3C);
    tick();
    check("gap.valid_drop", 32'(word_valid), 32'h0);

    // 4. Backpressure and overflow
    word_ready = 1'b0;
    send_byte(8'h11);
    check("bp.first_valid", 32'(word_valid), 32'h1);
    check("bp.first_out",   32'(word_out),   32'h11);
    check("bp.first_ovf",   32'(overflow),   32'h0);
    send_byte(8'h22);
    check("bp.held_out",    32'(word_out),   32'h11);
    check("bp.ovf_set",     32'(overflow),   32'h1);
    word_ready = 1'b1;
    tick();
    check("bp.xfer_valid",  32'(word_valid), 32'h0);
    check("bp.ovf_sticky",  32'(overflow),   32'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("bp.ovf_clr",     32'(overflow),   32'h0);

    // 5. Back-to-back words with ready held high
    b2b = 16'h5AC3;
    for (int i = 15; i >= 0; i--) begin
      send(b2b[i]);
      check("b2b.valid", 32'(word_valid), ((i == 8) || (i == 0)) ? 32'h1 : 32'h0);
      if (i == 8) check("b2b.word0", 32'(word_out), 32'h5A);
    end
    check("b2b.word1", 32'(word_out), 32'hC3);
    check("b2b.ovf",   32'(overflow), 32'h0);

    // 6a. resync mid-word keeps the pending word
    word_ready = 1'b0;
    send(1'b1); send(1'b0); send(1'b1);
    check("rs.bit_cnt_pre", 32'(bit_cnt), 32'h3);
    resync = 1'b1;
    bit_in = 1'b1;
    bit_en = 1'b1;
    tick();
    resync = 1'b0;
    bit_en = 1'b0;
    check("rs.locked",     32'(locked),     32'h0);
    check("rs.bit_cnt",    32'(bit_cnt),    32'h0);
    check("rs.pend_valid", 32'(word_valid), 32'h1);
    check("rs.pend_out",   32'(word_out),   32'hC3);
    word_ready = 1'b1;
    tick();
    check("rs.pend_xfer",  32'(word_valid), 32'h0);
    gap_word = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      send(gap_word[i]);
      check("rs.hunt_valid",  32'(word_valid), 32'h0);
      check("rs.hunt_locked", 32'(locked),     32'h0);
    end
    for (int i = 7; i >= 1; i--) begin
      send(sync_pat[i]);
      check("rs.resync_partial", 32'(locked), 32'h0);
    end
    send(sync_pat[0]);
    check("rs.relock",       32'(locked),     32'h1);
    check("rs.relock_valid", 32'(word_valid), 32'h0);

    // 6b. Overflow set beats clr_ovf, then async reset mid-word
    word_ready = 1'b0;
    send_byte(8'h77);
    check("ar.word_out", 32'(word_out), 32'h77);
    gap_word = 8'h88;
    for (int i = 7; i >= 1; i--) send(gap_word[i]);
    clr_ovf = 1'b1;
    send(gap_word[0]);
    clr_ovf = 1'b0;
    check("ar.set_wins", 32'(overflow), 32'h1);
    check("ar.held_out", 32'(word_out), 32'h77);
    for (int i = 0; i < 5; i++) send(1'b1);
    check("ar.bit_cnt5", 32'(bit_cnt), 32'h5);
    #2;
    rst = 1'b0;
    #1;
    check_zero("ar.async");
    tick();
    rst = 1'b1;
    tick();
    check_zero("ar.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
